// File: rtl/tsc_param_ctr.sv
// Parameterised threshold counter. It fires a PULSE_LEN-cycle trigger every
// THRESHOLD qualifying increments, in periodic, one-shot or event-counting mode.
module tsc_param_ctr #(
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 200,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             event_in,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             trigger,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic [7:0]       fire_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        PULSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0]       MODE_ONESHOT = 2'b01;
    localparam logic [1:0]       MODE_EVENT   = 2'b10;
    localparam logic [1:0]       MODE_OFF     = 2'b11;
    localparam logic [WIDTH-1:0] LAST_COUNT   = WIDTH'(THRESHOLD - 1);
    localparam logic [7:0]       LAST_PULSE   = 8'(PULSE_LEN - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             trigger_q, trigger_d;
    logic [7:0]       fire_count_q, fire_count_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    logic             qualify;

    assign qualify = en && ((mode != MODE_EVENT) || event_in);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        trigger_d    = trigger_q;
        fire_count_d = fire_count_q;
        pulse_cnt_d  = pulse_cnt_q;

        if (clear) begin
            state_d     = IDLE;
            count_d     = '0;
            trigger_d   = 1'b0;
            pulse_cnt_d = '0;
        end else if (mode == MODE_OFF && state_q != DONE) begin
            // DONE is sticky: only clear or reset can release it.
            state_d     = IDLE;
            count_d     = '0;
            trigger_d   = 1'b0;
            pulse_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) state_d = COUNT;
                end
                COUNT: begin
                    if (qualify) begin
                        if (count_q == LAST_COUNT) begin
                            state_d     = PULSE;
                            count_d     = '0;
                            trigger_d   = 1'b1;
                            pulse_cnt_d = '0;
                            if (fire_count_q != 8'hFF) fire_count_d = fire_count_q + 8'd1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (pulse_cnt_q == LAST_PULSE) begin
                        pulse_cnt_d = '0;
                        if (mode == MODE_ONESHOT) begin
                            state_d   = DONE;
                            trigger_d = 1'b1;
                        end else begin
                            state_d   = COUNT;
                            trigger_d = 1'b0;
                        end
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    trigger_d = 1'b1;
                    count_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            trigger_q    <= 1'b0;
            fire_count_q <= '0;
            pulse_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            trigger_q    <= trigger_d;
            fire_count_q <= fire_count_d;
            pulse_cnt_q  <= pulse_cnt_d;
        end
    end

    assign trigger    = trigger_q;
    assign count      = count_q;
    assign state      = state_q;
    assign fire_count = fire_count_q;

endmodule

// File: doc/tsc_param_ctr.md
TSC_PARAM_CTR -- requirements
Module: tsc_param_ctr

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (2..16).
REQ-002 Parameter THRESHOLD, default 200, qualifying increments per fire (1..2^WIDTH-1).
REQ-003 Parameter PULSE_LEN, default 4, trigger pulse length in cycles (1..255).
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  count enable.
REQ-007 event_in  input  1  count qualifier, used in event mode only.
REQ-008 mode  input  2  operating mode:
- 00 periodic
- 01 one-shot sticky
- 10 event-count periodic
- 11 disabled
REQ-009 clear  input  1  synchronous soft clear.
REQ-010 trigger  output  1  registered trigger.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 state  output  2  FSM state encoding: IDLE=00, COUNT=01, PULSE=10, DONE=11.
REQ-013 fire_count  output  8  number of PULSE entries, saturating at 255.

Function
REQ-014 Priority per edge: rst, then clear, then mode==11, then normal FSM.
REQ-015 clear=1 shall force IDLE, count=0, pulse counter=0 and trigger=0, and leave fire_count unchanged.
REQ-016 mode==11 in IDLE, COUNT or PULSE shall force IDLE, count=0 and trigger=0; in DONE it shall have no effect.
REQ-017 IDLE->COUNT when en=1 and mode!=11; this transition edge shall not increment count.
REQ-018 In COUNT, a qualifying increment is en=1 for modes 00/01, or en=1 AND event_in=1 for mode 10.
REQ-019 In COUNT with en=0, or with mode 10 and event_in=0, count shall hold.
REQ-020 In COUNT, a qualifying increment with count==THRESHOLD-1 shall move to PULSE, set count=0, set trigger=1 and increment fire_count (saturating).
REQ-021 Any other qualifying increment shall add 1 to count; count shall never reach THRESHOLD.
REQ-022 In PULSE:
- trigger=1 for exactly PULSE_LEN cycles, with no counting.
- On the last cycle, mode 00/10 -> COUNT with trigger=0.
- On the last cycle, mode 01 -> DONE with trigger=1.
REQ-023 In DONE, trigger shall stay 1 and count stay 0 until clear or rst; en, event_in and mode shall be ignored.
REQ-024 Mode is sampled every edge; a change mid-COUNT shall keep the current count and apply the new qualification from the next edge.
REQ-025 Latency: trigger rises THRESHOLD+1 edges after en is first sampled high in IDLE (modes 00/01, en held high).
REQ-026 Periodic steady-state period shall be THRESHOLD+PULSE_LEN cycles, with trigger high for PULSE_LEN of them.
REQ-027 All outputs shall be driven directly from registers.

Reset
REQ-028 rst=0 shall asynchronously set state=IDLE, count=0, trigger=0, fire_count=0 and pulse counter=0.
REQ-029 Reset asserted mid-PULSE or in DONE shall drop trigger immediately, without waiting for clk.
REQ-030 After rst deasserts, the first active edge shall follow REQ-017.

Verification
REQ-031 THRESHOLD=8, PULSE_LEN=4, mode=00, en=1 from reset release -> trigger rises after edge 9, is high edges 9-12, low for 8 cycles, then rises again; fire_count=2 after the second rise.
REQ-032 mode=01, same parameters -> trigger rises after edge 9 and stays 1, state=11; clear=1 for one edge -> state=00, trigger=0, fire_count=1.
REQ-033 mode=10, en=1, event_in pulsed on every 3rd cycle -> count steps once per event; trigger rises on the edge of the 8th event.
REQ-034 mode=00, en toggled low for 5 cycles at count=5 -> count holds 5; trigger delayed by exactly 5 cycles vs REQ-031.
REQ-035 rst driven low asynchronously mid-PULSE -> trigger=0 and count=0 before the next clk edge; fire_count=0.
REQ-036 mode=00 with fire_count forced to 255 by 255 periods -> fire_count stays 255 after further fires; mode=11 mid-COUNT -> state=00, count=0 next edge.
